mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Word-granular backing memory that answers the cache's external memory interface (the responder end of it).
//  Accepts single-word read/write requests under a ready handshake and queues them in order.
//  Services each request after a programmable wait and returns read data with a one-cycle valid pulse.
//  Sits between the instruction/data caches (or their arbiter) and the simulation/FPGA RAM.
// PARAMETERS
//  ADDR_W   12  word-address bits; array holds 2**ADDR_W 32-bit words
//  LATENCY   2  wait cycles per request in engine (>=0); sets turnaround below
//  QDEPTH    4  request queue entries; power of two, >=2
// PORTS
//  i_clk        in   1   clock
//  i_rst        in   1   synchronous active-high reset
//  o_mem_ready  out  1   request can be accepted this cycle (queue not full)
//  i_mem_addr   in   32  byte address; word index = i_mem_addr[ADDR_W+1:2]
//  i_mem_ren    in   1   read request
//  i_mem_wen    in   1   write request (full word, no mask)
//  i_mem_wdata  in   32  write data
//  o_mem_rdata  out  32  read data, valid only while o_mem_valid
//  o_mem_valid  out  1   one-cycle pulse per completed read, in request order
//  o_mem_err    out  1   one-cycle pulse: illegal request (ren & wen) seen
// BEHAVIOUR
//  Reset: queue emptied, engine IDLE, o_mem_valid=0, o_mem_rdata=0, o_mem_err=0, o_mem_ready=0 during reset cycle.
//   Array contents are NOT cleared. Requests queued or in service at reset are dropped (pending writes not applied).
//  o_mem_ready = !i_rst & (count < QDEPTH); count is registered, so ready is never combinational on inputs.
//  Accept: cycle with o_mem_ready & (ren ^ wen) pushes {wen, addr[ADDR_W+1:2], wdata} at the clock edge.
//   ren|wen while !o_mem_ready: ignored, no side effect (requester must hold/retry).
//   ren & wen together: not accepted; o_mem_err=1 next cycle.
//  Addressing: addr[1:0] and bits above ADDR_W+1 ignored (aliasing wraps modulo array size).
//  Engine FSM: IDLE -> WAIT -> IDLE.
//   IDLE: queue non-empty -> pop head at edge, cnt<=LATENCY, go WAIT.
//   WAIT: cnt!=0 -> cnt<=cnt-1. cnt==0 -> perform access at edge, go IDLE:
//    write: mem[idx]<=wdata. read: o_mem_rdata<=mem[idx], o_mem_valid<=1 for one cycle.
//  Timing: request accepted in cycle t into empty queue with engine IDLE -> o_mem_valid in cycle t+LATENCY+3.
//   Engine occupies LATENCY+2 cycles per request; throughput 1/(LATENCY+2).
//  Ordering: strictly FIFO; a read after a write to same word returns written data.
//  Push and pop same edge: both occur, count unchanged. Full: no push even if pop on same edge.
//  Pointers wrap modulo QDEPTH; count width $clog2(QDEPTH)+1.
//  o_mem_rdata holds last read value between pulses (reset value 0).
// CONFIGURATION
//  MEM_WRITE_ACK_EN defined: writes also pulse o_mem_valid on completion with o_mem_rdata=written data.
//  Not defined: o_mem_valid pulses for reads only; writes complete silently.
// TESTING (LATENCY=2, QDEPTH=4, ADDR_W=12)
//  Write 0xDEADBEEF @0x40 in cycle 5, read 0x40 in cycle 6 -> read valid cycle 14, rdata=0xDEADBEEF, no valid for write (macro off).
//  Reads 0x00,0x04,0x08,0x0C cycles 10-13 after preload 1..4 -> valids cycles 15,19,23,27, rdata 1,2,3,4 in order.
//  Six back-to-back reads from cycle 10 -> o_mem_ready low once count=4; late requests ignored until a pop, none lost when held.
//  ren=wen=1 in cycle 3 -> o_mem_err=1 cycle 4, nothing queued, no valid ever.
//  Write queued then i_rst in cycle of its WAIT -> after reset, read of that word returns pre-write value; o_mem_valid=0 in reset.
//  Address 0x4000_0040 read -> returns mem word 0x10 (alias of 0x40); MEM_WRITE_ACK_EN on -> write valid pulse with wdata.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: in-order queued word memory with programmable service latency; MEM_WRITE_ACK_EN adds write completion pulses
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_addr,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_valid,
  output logic        o_mem_err
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int EW = 1 + ADDR_W + 32;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] fifo_q [QDEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic [EW-1:0] op_q, op_d;
  logic [CW-1:0] lat_q, lat_d;
  logic [31:0] mem_q [2**ADDR_W];
  logic push, pop, fire, valid_d, op_wen;
  logic [ADDR_W-1:0] op_idx;
  logic [31:0] op_wdata;
  logic valid_q, err_q;
  logic [31:0] rdata_q;
  logic unused_addr;
  assign unused_addr = ^{i_mem_addr[31:ADDR_W+2], i_mem_addr[1:0]};
  assign o_mem_ready = !i_rst && (cnt_q < (PW+1)'(QDEPTH));
  assign push = o_mem_ready && (i_mem_ren ^ i_mem_wen);
  assign {op_wen, op_idx, op_wdata} = op_q;
  assign o_mem_rdata = rdata_q;
  assign o_mem_valid = valid_q;
  assign o_mem_err = err_q;
`ifdef MEM_WRITE_ACK_EN
  assign valid_d = fire;
`else
  assign valid_d = fire && !op_wen;
`endif
  // engine: IDLE pops the queue head, WAIT counts down then performs the access; nothing completes during reset
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    op_d = op_q;
    pop = 1'b0;
    fire = 1'b0;
    if (!i_rst && state_q == IDLE && cnt_q != '0) begin
      pop = 1'b1;
      op_d = fifo_q[rp_q];
      lat_d = CW'(LATENCY);
      state_d = WAIT;
    end else if (!i_rst && state_q == WAIT) begin
      fire = (lat_q == '0);
      lat_d = fire ? lat_q : lat_q - 1'b1;
      state_d = fire ? IDLE : WAIT;
    end
  end
  // engine state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      lat_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
    end
  end
  // datapath storage: queue entries, in-service request and the backing array are never cleared
  always_ff @(posedge i_clk) begin
    op_q <= op_d;
    if (push) fifo_q[wp_q] <= {i_mem_wen, i_mem_addr[ADDR_W+1:2], i_mem_wdata};
    if (fire && op_wen) mem_q[op_idx] <= op_wdata;
  end
  // queue pointers and occupancy; a full queue cannot push even when popping on the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + PW'(push);
      rp_q <= rp_q + PW'(pop);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // response outputs: valid/err pulse one cycle, rdata holds the last returned word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      err_q <= i_mem_ren && i_mem_wen;
      if (valid_d) rdata_q <= op_wen ? op_wdata : mem_q[op_idx];
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder (LATENCY=2, QDEPTH=4, ADDR_W=12)
module tb_mem_responder;
  localparam int LAT = 2;
  localparam int QD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic ready, valid, err;
  logic [31:0] rdata;
  mem_responder #(.ADDR_W(12), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .i_clk(clk), .i_rst(rst), .o_mem_ready(ready), .i_mem_addr(addr),
    .i_mem_ren(ren), .i_mem_wen(wen), .i_mem_wdata(wdata),
    .o_mem_rdata(rdata), .o_mem_valid(valid), .o_mem_err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic w;
    logic [11:0] idx;
    logic [31:0] d;
    int start;
    int done;
  } op_t;
  op_t ops[$];
  op_t op;
  logic [31:0] rm [4096];
  int tests = 0, fails = 0;
  int cyc = 0, free_at = 0, qn, st;
  logic mon_en = 1'b0, prev_rst = 1'b1, err_exp = 1'b0, exp_v;
  logic [31:0] last_rd = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        if (prev_rst) begin
          chk("rst_rdata", rdata, 32'd0);
          chk("rst_err", {31'b0, err}, 32'd0);
        end
        ops.delete();
        free_at = 0;
        err_exp = 1'b0;
        last_rd = '0;
      end else begin
        qn = 0;
        exp_v = 1'b0;
        foreach (ops[i]) if (ops[i].start >= cyc) qn++;
        chk("ready", {31'b0, ready}, {31'b0, qn < QD});
        if (ops.size() > 0 && ops[0].done == cyc) begin
          op = ops.pop_front();
          if (op.w) begin
            rm[op.idx] = op.d;
`ifdef MEM_WRITE_ACK_EN
            exp_v = 1'b1;
            last_rd = op.d;
`endif
          end else begin
            exp_v = 1'b1;
            last_rd = rm[op.idx];
          end
        end
        chk("valid", {31'b0, valid}, {31'b0, exp_v});
        chk(exp_v ? "rdata" : "rdata_hold", rdata, last_rd);
        chk("err", {31'b0, err}, {31'b0, err_exp});
        err_exp = ren & wen;
        if (qn < QD && (ren ^ wen)) begin
          st = (cyc + 1 > free_at) ? cyc + 1 : free_at;
          free_at = st + LAT + 2;
          ops.push_back('{w: wen, idx: addr[13:2], d: wdata, start: st, done: st + LAT + 2});
        end
      end
      prev_rst = rst;
    end
  end
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    ren = !w;
    wen = w;
    addr = a;
    wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 200);
    chk("req_accept_timeout", {31'b0, n < 200}, 32'd1);
    @(posedge clk);
    #1;
    ren = 1'b0;
    wen = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while (ops.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", {31'b0, ops.size() == 0}, 32'd1);
    idle(2);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    req(1'b0, 32'h0000_0040, 32'h0);
    drain();
    for (int i = 0; i < 4; i++) req(1'b1, 32'(i * 4), 32'(i + 1));
    req(1'b1, 32'h0000_0080, 32'h1111_1111);
    drain();
    for (int i = 0; i < 4; i++) req(1'b0, 32'(i * 4), 32'h0);
    drain();
    for (int i = 0; i < 6; i++) req(1'b0, (i < 4) ? 32'(i * 4) : ((i == 4) ? 32'h40 : 32'h80), 32'h0);
    drain();
    ren = 1'b1;
    wen = 1'b1;
    addr = 32'h0000_0100;
    wdata = 32'hBAD0_BAD0;
    idle(1);
    ren = 1'b0;
    wen = 1'b0;
    idle(LAT + 6);
    req(1'b0, 32'h4000_0040, 32'h0);
    req(1'b0, 32'hFFFF_C00C, 32'h0);
    drain();
    for (int i = 0; i < 6; i++) req(1'b1, 32'h200 + 32'(i * 4), $urandom);
    for (int i = 5; i >= 0; i--) req(1'b0, 32'h200 + 32'(i * 4), 32'h0);
    drain();
    req(1'b1, 32'h0000_0080, 32'h2222_2222);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    req(1'b0, 32'h0000_0080, 32'h0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
